// File: rtl/delta_mod_pkg.sv
// delta_mod_pkg: shared widths, spike encodings and TT pin-slice positions for the delta modulator.
package delta_mod_pkg;
    localparam int DATA_W = 4;
    localparam logic [1:0] SPK_NONE = 2'b00;
    localparam logic [1:0] SPK_ON   = 2'b01;
    localparam logic [1:0] SPK_OFF  = 2'b10;
    localparam int TH_LSB     = 0;
    localparam int DATA_LSB   = 4;
    localparam int OFF_EN_BIT = 0;
    localparam int LOAD_BIT   = 1;
    localparam int FORCE_LSB  = 4;
    localparam int SPIKE_LSB  = 0;
    localparam int PREV_LSB   = 4;
endpackage

// File: rtl/delta_modulation_if.sv
// delta_modulation_if: Tiny Tapeout pin bundle (enable plus dedicated and bidirectional pins).
interface delta_modulation_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
    modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/delta_mod_core.sv
// delta_mod_core: reference register, threshold comparators and registered ON/OFF spike pulses.
// Build option DELTA_STEP_EN: on a spike the reference steps by the threshold instead of jumping to data.
module delta_mod_core
    import delta_mod_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DATA_W-1:0] data,
    input  logic [DATA_W-1:0] threshold,
    input  logic              off_en,
    input  logic              load,
    input  logic [DATA_W-1:0] load_val,
    output logic [1:0]        spike,
    output logic [DATA_W-1:0] prev
);
    logic [DATA_W-1:0] r_prev;
    logic [1:0]        r_spike;
    logic [DATA_W:0]   w_th;
    logic [DATA_W:0]   w_up;
    logic [DATA_W:0]   w_dn;
    logic              w_rise;
    logic              w_fall;
    logic [DATA_W-1:0] w_on_val;
    logic [DATA_W-1:0] w_off_val;
    logic [DATA_W-1:0] w_nxt_prev;
    logic [1:0]        w_nxt_spike;
    // a zero threshold acts as one so equal samples never fire
    assign w_th   = {1'b0, (threshold == '0) ? DATA_W'(1) : threshold};
    assign w_up   = {1'b0, data} - {1'b0, r_prev};
    assign w_dn   = {1'b0, r_prev} - {1'b0, data};
    assign w_rise = (data >= r_prev) && (w_up >= w_th);
    assign w_fall = (r_prev > data) && (w_dn >= w_th);
`ifdef DELTA_STEP_EN
    assign w_on_val  = r_prev + w_th[DATA_W-1:0];
    assign w_off_val = r_prev - w_th[DATA_W-1:0];
`else
    assign w_on_val  = data;
    assign w_off_val = data;
`endif
    assign w_nxt_prev  = !en    ? r_prev   :
                         load   ? load_val :
                         w_rise ? w_on_val :
                         w_fall ? w_off_val : r_prev;
    assign w_nxt_spike = (!en || load)     ? SPK_NONE :
                         w_rise            ? SPK_ON   :
                         (w_fall && off_en) ? SPK_OFF : SPK_NONE;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prev  <= '0;
            r_spike <= SPK_NONE;
        end else begin
            r_prev  <= w_nxt_prev;
            r_spike <= w_nxt_spike;
        end
    end
    assign spike = r_spike;
    assign prev  = r_prev;
endmodule

// File: rtl/delta_modulation.sv
// delta_modulation: TT tile wrapper mapping pins onto delta_mod_core; bidirectional pins are unused inputs.
// Honours build option DELTA_STEP_EN through the core.
module delta_modulation
    import delta_mod_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    delta_modulation_if.slave bus
);
    logic [1:0]        w_spike;
    logic [DATA_W-1:0] w_prev;
    logic [7:0]        w_uo;
    logic              w_unused;
    delta_mod_core u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (bus.ena),
        .data      (bus.ui_in[DATA_LSB +: DATA_W]),
        .threshold (bus.ui_in[TH_LSB +: DATA_W]),
        .off_en    (bus.uio_in[OFF_EN_BIT]),
        .load      (bus.uio_in[LOAD_BIT]),
        .load_val  (bus.uio_in[FORCE_LSB +: DATA_W]),
        .spike     (w_spike),
        .prev      (w_prev)
    );
    always_comb begin
        w_uo = '0;
        w_uo[SPIKE_LSB +: 2]     = w_spike;
        w_uo[PREV_LSB +: DATA_W] = w_prev;
    end
    assign bus.uo_out  = w_uo;
    assign bus.uio_out = '0;
    assign bus.uio_oe  = '0;
    assign w_unused    = &{1'b0, bus.uio_in[3:2]};
endmodule

// File: tb/tb_delta_modulation.sv
// tb_delta_modulation: directed steps with a scoreboard of expected uo_out values; covers DELTA_STEP_EN builds too.
module tb_delta_modulation;
    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    typedef struct {
        string      tag;
        logic [7:0] exp;
    } sb_t;
    sb_t sb_q[$];
    delta_modulation_if bus ();
    delta_modulation dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    // drive one cycle of inputs, queue the expectation, then compare 1 time unit after the edge
    task automatic step(input string tag, input logic rn, input logic en, input logic [3:0] data,
                        input logic [3:0] th, input logic off, input logic ld, input logic [3:0] fv,
                        input logic [7:0] exp);
        sb_t e;
        rst_n      = rn;
        bus.ena    = en;
        bus.ui_in  = {data, th};
        bus.uio_in = {fv, 2'b00, ld, off};
        sb_q.push_back('{tag, exp});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        checks++;
        assert (bus.uo_out === e.exp) else begin
            errors++;
            $error("FAIL %s: uo_out=%h expected %h", e.tag, bus.uo_out, e.exp);
        end
    endtask
    task automatic load(input string tag, input logic [3:0] v);
        step(tag, 1'b1, 1'b1, 4'd0, 4'd1, 1'b1, 1'b1, v, {v, 4'h0});
    endtask
    initial begin
        rst_n = 1'b0;
        bus.ena = 1'b1;
        bus.ui_in = '0;
        bus.uio_in = '0;
        step("rst0", 1'b0, 1'b1, 4'd9, 4'd2, 1'b0, 1'b0, 4'd0, 8'h00);
        step("rst1", 1'b0, 1'b1, 4'd9, 4'd2, 1'b0, 1'b0, 4'd0, 8'h00);
`ifdef DELTA_STEP_EN
        step("rst_release", 1'b1, 1'b1, 4'd9, 4'd2, 1'b0, 1'b0, 4'd0, 8'h21);
`else
        step("rst_release", 1'b1, 1'b1, 4'd9, 4'd2, 1'b0, 1'b0, 4'd0, 8'h91);
`endif
        load("load4", 4'd4);
        step("rise_small", 1'b1, 1'b1, 4'd6, 4'd3, 1'b0, 1'b0, 4'd0, 8'h40);
        step("rise_on", 1'b1, 1'b1, 4'd7, 4'd3, 1'b0, 1'b0, 4'd0, 8'h71);
        step("rise_hold", 1'b1, 1'b1, 4'd7, 4'd3, 1'b0, 1'b0, 4'd0, 8'h70);
        load("load10a", 4'd10);
        step("fall_off", 1'b1, 1'b1, 4'd8, 4'd2, 1'b1, 1'b0, 4'd0, 8'h82);
        load("load10b", 4'd10);
        step("fall_silent", 1'b1, 1'b1, 4'd8, 4'd2, 1'b0, 1'b0, 4'd0, 8'h80);
        step("load_prio", 1'b1, 1'b1, 4'd0, 4'd1, 1'b1, 1'b1, 4'd12, 8'hC0);
`ifdef DELTA_STEP_EN
        step("after_load", 1'b1, 1'b1, 4'd0, 4'd1, 1'b1, 1'b0, 4'd0, 8'hB2);
`else
        step("after_load", 1'b1, 1'b1, 4'd0, 4'd1, 1'b1, 1'b0, 4'd0, 8'h02);
`endif
        load("load5", 4'd5);
        step("th0_equal", 1'b1, 1'b1, 4'd5, 4'd0, 1'b1, 1'b0, 4'd0, 8'h50);
        step("th0_plus1", 1'b1, 1'b1, 4'd6, 4'd0, 1'b1, 1'b0, 4'd0, 8'h61);
        load("load0a", 4'd0);
        step("ena_off", 1'b1, 1'b0, 4'd15, 4'd1, 1'b1, 1'b0, 4'd0, 8'h00);
        step("ena_off_load", 1'b1, 1'b0, 4'd15, 4'd1, 1'b1, 1'b1, 4'd9, 8'h00);
`ifdef DELTA_STEP_EN
        step("ena_back", 1'b1, 1'b1, 4'd15, 4'd1, 1'b1, 1'b0, 4'd0, 8'h11);
`else
        step("ena_back", 1'b1, 1'b1, 4'd15, 4'd1, 1'b1, 1'b0, 4'd0, 8'hF1);
`endif
        load("load0b", 4'd0);
        step("bnd_15_0", 1'b1, 1'b1, 4'd15, 4'd15, 1'b1, 1'b0, 4'd0, 8'hF1);
        load("load0c", 4'd0);
        step("bnd_up14", 1'b1, 1'b1, 4'd14, 4'd15, 1'b1, 1'b0, 4'd0, 8'h00);
        load("load15", 4'd15);
        step("bnd_dn14", 1'b1, 1'b1, 4'd1, 4'd15, 1'b1, 1'b0, 4'd0, 8'hF0);
        step("bnd_dn15", 1'b1, 1'b1, 4'd0, 4'd15, 1'b1, 1'b0, 4'd0, 8'h02);
        load("load0d", 4'd0);
`ifdef DELTA_STEP_EN
        step("track1", 1'b1, 1'b1, 4'd15, 4'd4, 1'b1, 1'b0, 4'd0, 8'h41);
        step("track2", 1'b1, 1'b1, 4'd15, 4'd4, 1'b1, 1'b0, 4'd0, 8'h81);
        step("track3", 1'b1, 1'b1, 4'd15, 4'd4, 1'b1, 1'b0, 4'd0, 8'hC1);
        step("track4", 1'b1, 1'b1, 4'd15, 4'd4, 1'b1, 1'b0, 4'd0, 8'hC0);
`else
        step("track1", 1'b1, 1'b1, 4'd15, 4'd4, 1'b1, 1'b0, 4'd0, 8'hF1);
        step("track2", 1'b1, 1'b1, 4'd15, 4'd4, 1'b1, 1'b0, 4'd0, 8'hF0);
        step("track3", 1'b1, 1'b1, 4'd15, 4'd4, 1'b1, 1'b0, 4'd0, 8'hF0);
        step("track4", 1'b1, 1'b1, 4'd15, 4'd4, 1'b1, 1'b0, 4'd0, 8'hF0);
`endif
        load("load7", 4'd7);
        step("rst_over_load", 1'b0, 1'b1, 4'd15, 4'd1, 1'b1, 1'b1, 4'd9, 8'h00);
        checks++;
        assert ({bus.uio_out, bus.uio_oe} === 16'h0000) else begin
            errors++;
            $error("FAIL tieoff: uio_out/uio_oe=%h expected 0000", {bus.uio_out, bus.uio_oe});
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
